// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch front end: FSM encoding,
// the FIFO entry layout and the branch-target helper that the decode
// datapath also uses.
package fetch_queue_pkg;

  // Fetch FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;  // no request outstanding
  localparam logic [1:0] ST_WAIT = 2'd1;  // one request outstanding, result wanted
  localparam logic [1:0] ST_DROP = 2'd2;  // one request outstanding, result discarded

  // Bytes per instruction word
  localparam int unsigned WORD_BYTES = 4;

  // One buffered instruction together with the address it was fetched from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Branch target: pc + 4 + (sign_extend(imm16) << 2), wrapping mod 2^32
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [15:0] imm16);
    logic signed [31:0] offset;
    offset = {{14{imm16[15]}}, imm16, 2'b00};
    return pc + 32'(WORD_BYTES) + $unsigned(offset);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of {pc, inst} pairs with an
// occupancy count and a flush that empties it on the next edge, overriding
// any push or pop in the same cycle. The head is read straight out of the
// storage array, so a word pushed on one edge is visible the cycle after.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     wr_data,
  input  logic             pop,
  output fetch_entry_t     rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointers and count; flush wins over push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; holds data only, so it is not reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  // Head forced to zero when empty so the outputs read 0 after reset
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end. Owns the fetch PC, keeps at most one request
// outstanding to a variable-latency instruction memory, buffers returned
// words in fetch_fifo and hands them to decode over valid/ready. A taken
// branch on an accepted instruction flushes the buffer, retargets the PC
// and turns any in-flight response into one that is thrown away.
//
// Build option: define FETCH_BYPASS_EN to let a response arriving into an
// empty buffer appear on inst/inst_pc/inst_valid in the same cycle (and be
// consumed there if decode is ready), saving one cycle of latency.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        nPC_sel,
  input  logic [15:0] imm16
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;

  fetch_entry_t     fifo_head;
  fetch_entry_t     fifo_wr;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  logic             bypass;
  logic             accept;
  logic             redirect;
  logic             issue;
  logic             push;
  logic             pop;
  logic [31:0]      target;

`ifdef FETCH_BYPASS_EN
  // Response lands while the buffer is empty: present it directly
  assign bypass = fifo_empty && (state_q == ST_WAIT) && imem_rvalid;
`else
  assign bypass = 1'b0;
`endif

  // Decode-facing head: either the bypassed response or the FIFO head
  always_comb begin
    if (bypass) begin
      inst       = imem_rdata;
      inst_pc    = req_pc_q;
      inst_valid = 1'b1;
    end else begin
      inst       = fifo_head.inst;
      inst_pc    = fifo_head.pc;
      inst_valid = !fifo_empty;
    end
  end

  assign accept   = inst_valid && inst_ready;
  assign redirect = accept && nPC_sel;
  assign target   = branch_target(inst_pc, imm16);

  // A new request only from IDLE, only with a slot guaranteed, and never in
  // the cycle a redirect is retargeting the PC. Gated by rst so the strobe
  // stays low while reset is held.
  assign issue     = (state_q == ST_IDLE) && !redirect &&
                     (fifo_count < CNT_W'(DEPTH)) && !rst;
  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;

  // A bypassed word that decode takes this cycle never enters the FIFO
  assign pop     = accept && !bypass;
  assign push    = (state_q == ST_WAIT) && imem_rvalid && !redirect &&
                   !(bypass && inst_ready) && !fifo_full;
  assign fifo_wr = '{pc: req_pc_q, inst: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .push    (push),
    .wr_data (fifo_wr),
    .pop     (pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FSM next state and fetch PC; redirect overrides the sequential PC
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d    = ST_WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
        end
      end
      ST_WAIT: begin
        // A response coinciding with a redirect is simply not pushed
        if (imem_rvalid)   state_d = ST_IDLE;
        else if (redirect) state_d = ST_DROP;
      end
      ST_DROP: begin
        if (imem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirect) fetch_pc_d = target;
  end

  // Control registers: FSM state and fetch PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Address of the outstanding request, tagged onto its response
  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
  end

endmodule
